// File: rtl/branch_feedback_scheduler_pkg.sv
// rtl/branch_feedback_scheduler_pkg.sv - shared types and sizing for the branch feedback scheduler
package branch_feedback_scheduler_pkg;

    localparam int OP_ADDR_WIDTH     = 32;
    localparam int NUM_OF_GRADUATE   = 2;
    localparam int BP_INDEX_WIDTH    = 10;
    localparam int BP_FB_QUEUE_DEPTH = 8;
    localparam int BP_CLEAR_ENTRIES  = 1024;

    typedef struct packed {
        logic                     valid;
        logic [OP_ADDR_WIDTH-1:0] op_addr;
        logic                     taken;
    } is_taken_feedback_to_pred_t;

    typedef enum logic [1:0] {
        INIT_CLEAR,
        CLEAR,
        RUN
    } sched_state_e;

endpackage

// File: rtl/branch_feedback_scheduler_fb_compact_fifo.sv
// rtl/branch_feedback_scheduler_fb_compact_fifo.sv - multi-push single-pop FIFO with compacted writes
module fb_compact_fifo
    import branch_feedback_scheduler_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  is_taken_feedback_to_pred_t i_push [NUM_IN],
    input  logic                       i_push_en,
    input  logic                       i_pop,
    output is_taken_feedback_to_pred_t o_head,
    output logic [PW-1:0]              o_occupancy,
    output logic                       o_ready
);

    is_taken_feedback_to_pred_t r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW-1:0] w_occ;
    logic [PW-1:0] w_npush;
    logic [AW-1:0] w_waddr [NUM_IN];
    logic          w_do_pop;

    // Each valid port lands at tail + (number of valid ports below it), so holes never form.
    always_comb begin
        w_npush = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_waddr[i] = AW'(r_wr + w_npush);
            w_npush    = w_npush + PW'(i_push[i].valid);
        end
    end

    assign w_occ       = r_wr - r_rd;
    assign w_do_pop    = i_pop && (w_occ != '0);
    assign o_occupancy = w_occ;
    assign o_ready     = (PW'(DEPTH) - w_occ) >= PW'(NUM_IN);
    assign o_head      = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clock) begin
        if (i_push_en) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (i_push[i].valid) begin
                    r_mem[w_waddr[i]] <= i_push[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push_en) begin
                r_wr <= r_wr + w_npush;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + PW'(1);
            end
        end
    end

endmodule

// File: rtl/branch_feedback_scheduler.sv
// rtl/branch_feedback_scheduler.sv - serializes graduated branch outcomes and sequences table clears
module branch_feedback_scheduler
    import branch_feedback_scheduler_pkg::*;
#(
    parameter int NUM_IN        = NUM_OF_GRADUATE,
    parameter int QUEUE_DEPTH   = BP_FB_QUEUE_DEPTH,
    parameter int INDEX_WIDTH   = BP_INDEX_WIDTH,
    parameter int CLEAR_ENTRIES = BP_CLEAR_ENTRIES,
    localparam int OW           = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  is_taken_feedback_to_pred_t fb_in [NUM_IN],
    output logic                       fb_ready,
    input  logic                       clear_req,
    output is_taken_feedback_to_pred_t upd_out,
    output logic                       clr_valid,
    output logic [INDEX_WIDTH-1:0]     clr_index,
    output logic                       busy,
    output logic [OW-1:0]              occupancy,
    output logic                       overflow
);

    sched_state_e               r_state;
    sched_state_e               w_state_next;
    logic [INDEX_WIDTH-1:0]     r_clr_index;
    logic                       r_overflow;
    logic                       w_ready;
    logic                       w_any_valid;
    logic                       w_last_index;
    logic                       w_run;
    logic [OW-1:0]              w_occ;
    is_taken_feedback_to_pred_t w_head;

    fb_compact_fifo #(
        .NUM_IN (NUM_IN),
        .DEPTH  (QUEUE_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (fb_in),
        .i_push_en   (w_ready),
        .i_pop       (w_run),
        .o_head      (w_head),
        .o_occupancy (w_occ),
        .o_ready     (w_ready)
    );

    always_comb begin
        w_any_valid = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_any_valid = w_any_valid | fb_in[i].valid;
        end
    end

    assign w_run        = (r_state == RUN);
    assign w_last_index = (r_clr_index == INDEX_WIDTH'(CLEAR_ENTRIES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INIT_CLEAR, CLEAR: if (w_last_index) w_state_next = RUN;
            RUN:               if (clear_req)    w_state_next = CLEAR;
            default:           w_state_next = INIT_CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= INIT_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Index sits at zero throughout RUN, so a new sweep always starts from entry 0.
    always_ff @(posedge clock) begin
        if (reset || w_run || w_last_index) begin
            r_clr_index <= '0;
        end else begin
            r_clr_index <= r_clr_index + INDEX_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (!w_ready && w_any_valid) begin
            r_overflow <= 1'b1;
        end
    end

    always_comb begin
        upd_out       = w_head;
        upd_out.valid = w_run && (w_occ != '0);
    end

    assign fb_ready  = w_ready;
    assign clr_valid = !w_run;
    assign busy      = !w_run;
    assign clr_index = r_clr_index;
    assign occupancy = w_occ;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_branch_feedback_scheduler.sv
// tb/tb_branch_feedback_scheduler.sv - self-checking bench for branch_feedback_scheduler
module tb_branch_feedback_scheduler;
    import branch_feedback_scheduler_pkg::*;

    localparam int NCLR  = 1024;
    localparam int DEPTH = 8;

    logic                       clock = 1'b0;
    logic                       reset;
    is_taken_feedback_to_pred_t fb_in [2];
    logic                       fb_ready;
    logic                       clear_req;
    is_taken_feedback_to_pred_t upd_out;
    logic                       clr_valid;
    logic [9:0]                 clr_index;
    logic                       busy;
    logic [3:0]                 occupancy;
    logic                       overflow;

    branch_feedback_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .fb_in     (fb_in),
        .fb_ready  (fb_ready),
        .clear_req (clear_req),
        .upd_out   (upd_out),
        .clr_valid (clr_valid),
        .clr_index (clr_index),
        .busy      (busy),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of outstanding outcomes plus a "sweep position" counter.
    typedef struct {
        logic [31:0] a;
        logic        t;
    } ent_t;
    ent_t mq[$];
    int   m_idx;
    bit   m_run;
    bit   m_ovf;

    typedef struct {
        logic        v0;
        logic [31:0] a0;
        logic        t0;
        logic        v1;
        logic [31:0] a1;
        logic        t1;
        int          exp_occ;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic        exp_taken;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic v0, input logic [31:0] a0, input logic t0,
                              input logic v1, input logic [31:0] a1, input logic t1,
                              input logic cr);
        bit ready;
        if (reset) begin
            mq.delete();
            m_idx = 0;
            m_run = 0;
            m_ovf = 0;
        end else begin
            ready = (DEPTH - mq.size()) >= 2;
            if (m_run && mq.size() > 0) void'(mq.pop_front());
            if (ready) begin
                if (v0) mq.push_back('{a0, t0});
                if (v1) mq.push_back('{a1, t1});
            end else if (v0 || v1) begin
                m_ovf = 1;
            end
            if (!m_run) begin
                if (m_idx == NCLR - 1) begin
                    m_run = 1;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end else if (cr) begin
                m_run = 0;
                m_idx = 0;
            end
        end
    endtask

    task automatic compare_model();
        logic ev;
        ev = m_run && (mq.size() > 0);
        chk("busy", busy, !m_run);
        chk("clr_valid", clr_valid, !m_run);
        chk("clr_index", clr_index, m_idx);
        chk("occupancy", occupancy, mq.size());
        chk("fb_ready", fb_ready, (DEPTH - mq.size()) >= 2);
        chk("overflow", overflow, m_ovf);
        chk("upd_valid", upd_out.valid, ev);
        if (ev) begin
            chk("upd_addr", upd_out.op_addr, mq[0].a);
            chk("upd_taken", upd_out.taken, mq[0].t);
        end
    endtask

    task automatic tick(input logic v0, input logic [31:0] a0, input logic t0,
                        input logic v1, input logic [31:0] a1, input logic t1,
                        input logic cr);
        fb_in[0]  = '{valid: v0, op_addr: a0, taken: t0};
        fb_in[1]  = '{valid: v1, op_addr: a1, taken: t1};
        clear_req = cr;
        model_step(v0, a0, t0, v1, a1, t1, cr);
        @(posedge clock);
        #1;
        compare_model();
    endtask

    task automatic idle();
        tick(0, 32'h0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (busy && n < 2 * NCLR) begin
            idle();
            n++;
        end
        chk("wait_run_timeout", busy, 1'b0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        clear_req = 1'b0;
        fb_in[0]  = '0;
        fb_in[1]  = '0;

        // Reset state.
        idle();
        chk("reset_clr_index", clr_index, 10'd0);
        chk("reset_clr_valid", clr_valid, 1'b1);
        chk("reset_occ", occupancy, 4'd0);
        chk("reset_fb_ready", fb_ready, 1'b1);
        reset = 1'b0;

        // Initial sweep lasts exactly NCLR observed cycles.
        n = 0;
        while (busy && n < 2 * NCLR) begin
            n++;
            idle();
        end
        chk("init_sweep_len", n, NCLR);
        chk("run_after_sweep", busy, 1'b0);

        // Directed RUN-state vectors starting from an empty queue.
        vecs.push_back('{1, 32'h100, 1, 1, 32'h104, 0, 2, 1, 32'h100, 1});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   0, 1, 1, 32'h104, 0});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   0});
        vecs.push_back('{0, 32'h0,   0, 1, 32'h200, 1, 1, 1, 32'h200, 1});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   0});
        vecs.push_back('{1, 32'h300, 0, 0, 32'h0,   0, 1, 1, 32'h300, 0});
        vecs.push_back('{1, 32'h310, 1, 1, 32'h314, 1, 2, 1, 32'h310, 1});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   0, 1, 1, 32'h314, 1});
        vecs.push_back('{0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   0});
        foreach (vecs[k]) begin
            tick(vecs[k].v0, vecs[k].a0, vecs[k].t0, vecs[k].v1, vecs[k].a1, vecs[k].t1, 0);
            chk("vec_occ", occupancy, vecs[k].exp_occ);
            chk("vec_valid", upd_out.valid, vecs[k].exp_valid);
            if (vecs[k].exp_valid) begin
                chk("vec_addr", upd_out.op_addr, vecs[k].exp_addr);
                chk("vec_taken", upd_out.taken, vecs[k].exp_taken);
            end
        end

        // Fill during CLEAR with pairs until overflow.
        tick(0, 0, 0, 0, 0, 0, 1);
        chk("clear_entered", busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1, 32'h400 + 8 * i, i[0], 1, 32'h404 + 8 * i, ~i[0], 0);
        end
        chk("fill_overflow", overflow, 1'b1);
        chk("fill_occ", occupancy, 4'd8);
        chk("fill_ready_low", fb_ready, 1'b0);
        wait_run();
        for (int i = 0; i < 9; i++) idle();
        chk("fill_drained", occupancy, 4'd0);

        // clear_req in RUN with 3 queued entries.
        tick(1, 32'h500, 1, 1, 32'h504, 0, 0);
        tick(1, 32'h508, 1, 1, 32'h50c, 1, 0);
        chk("pre_clear_occ", occupancy, 4'd3);
        tick(0, 0, 0, 0, 0, 0, 1);
        chk("clear_from_run", busy, 1'b1);
        n = 0;
        while (busy && n < 2 * NCLR) begin
            if (upd_out.valid === 1'b0) n++;
            idle();
        end
        chk("clear_hold_len", n, NCLR);
        for (int i = 0; i < 3; i++) idle();

        // Reset mid-sweep with queued entries and a sticky overflow.
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(1, 32'h600, 0, 1, 32'h604, 1, 0);
        tick(1, 32'h608, 1, 1, 32'h60c, 0, 0);
        n = 0;
        while (clr_index != 10'd500 && n < 2 * NCLR) begin
            idle();
            n++;
        end
        chk("mid_sweep_occ", occupancy, 4'd4);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("midreset_index", clr_index, 10'd0);
        chk("midreset_occ", occupancy, 4'd0);
        chk("midreset_ovf", overflow, 1'b0);
        wait_run();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                 $urandom_range(0, 399) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
